// File: rtl/scan_pkg.sv
// Shared definitions for the scan controller: FSM states, command-to-SEL mapping,
// engine mode encoding and the cell-slice helper.
package scan_pkg;

  typedef enum logic [3:0] {
    IDLE, SEL1, SEL2, SEL3, SEL4, SHIFT, CAPTURE, UPDATE, RUN, WAIT
  } state_t;

  // Which SEL state commits which command when tms=1
  localparam state_t SEL_SHIFT   = SEL1;
  localparam state_t SEL_CAPTURE = SEL2;
  localparam state_t SEL_ENC     = SEL3;
  localparam state_t SEL_DEC     = SEL4;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  function automatic int cell_lsb(input int idx, input int cell_w);
    return idx * cell_w;
  endfunction

endpackage

// File: rtl/scan_cell_chain.sv
// Scan cell chain register: NUM_CELLS cells of CELL_W bits, cell 0 at the LSB (tdo) end.
// Update priority is parallel load, then single-cell write, then serial shift.
module scan_cell_chain
  import scan_pkg::*;
#(
  parameter int CELL_W    = 128,
  parameter int NUM_CELLS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shift_en,
  input  logic                          sdi,
  input  logic                          load_en,
  input  logic [CELL_W*NUM_CELLS-1:0]   load_data,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_CELLS)-1:0]  wr_idx,
  input  logic [CELL_W-1:0]             wr_data,
  output logic [CELL_W*NUM_CELLS-1:0]   chain
);

  localparam int TOT_W = CELL_W * NUM_CELLS;
  localparam int IDX_W = $clog2(NUM_CELLS);

  logic [TOT_W-1:0] chain_q;
  logic [TOT_W-1:0] chain_d;
  logic [TOT_W-1:0] wr_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
      localparam int LSB = cell_lsb(gi, CELL_W);
      assign wr_vec[LSB +: CELL_W] = (wr_en && (wr_idx == IDX_W'(gi))) ? wr_data
                                                                       : chain_q[LSB +: CELL_W];
    end
  endgenerate

  always_comb begin
    chain_d = chain_q;
    if (load_en) begin
      chain_d = load_data;
    end else if (wr_en) begin
      chain_d = wr_vec;
    end else if (shift_en) begin
      chain_d = {sdi, chain_q[TOT_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign chain = chain_q;

endmodule

// File: rtl/scan_ctrl.sv
// Boundary-scan controller: TMS-sequenced command FSM, scan chain, update register and
// crypto-engine handshake with timeout. Define SCAN_BYPASS_EN to add the 1-bit bypass path.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int CELL_W    = 128,
  parameter int NUM_CELLS = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic                          clk,
  input  logic                          trst,
  input  logic                          tms,
  input  logic                          tdi,
`ifdef SCAN_BYPASS_EN
  input  logic                          byp_sel,
`endif
  output logic                          tdo,
  input  logic [CELL_W*NUM_CELLS-1:0]   cap_data,
  output logic [CELL_W*NUM_CELLS-1:0]   upd_data,
  output logic                          upd_valid,
  output logic                          eng_start,
  output logic                          eng_mode,
  output logic [CELL_W-1:0]             eng_operand,
  input  logic                          eng_done,
  input  logic [CELL_W-1:0]             eng_result,
  output logic                          busy,
  output logic                          err
);

  localparam int TOT_W    = CELL_W * NUM_CELLS;
  localparam int CNT_W    = $clog2(TIMEOUT) + 1;
  localparam int IDX_W    = $clog2(NUM_CELLS);
  localparam int LAST_LSB = cell_lsb(NUM_CELLS - 1, CELL_W);

  state_t              state_q, state_d;
  logic                tdo_q, tdo_d;
  logic [TOT_W-1:0]    upd_data_q, upd_data_d;
  logic                upd_valid_q, upd_valid_d;
  logic                mode_q, mode_d;
  logic [CELL_W-1:0]   operand_q, operand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                shift_en;
  logic                load_en;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [TOT_W-1:0]    chain;

`ifdef SCAN_BYPASS_EN
  logic byp_q, byp_d;
`endif

  scan_cell_chain #(
    .CELL_W    (CELL_W),
    .NUM_CELLS (NUM_CELLS)
  ) u_chain (
    .clk       (clk),
    .rst       (trst),
    .shift_en  (shift_en),
    .sdi       (tdi),
    .load_en   (load_en),
    .load_data (cap_data),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (eng_result),
    .chain     (chain)
  );

  always_comb begin
    state_d     = state_q;
    tdo_d       = tdo_q;
    upd_data_d  = upd_data_q;
    upd_valid_d = 1'b0;
    mode_d      = mode_q;
    operand_d   = operand_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    shift_en    = 1'b0;
    load_en     = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = '0;
`ifdef SCAN_BYPASS_EN
    byp_d       = byp_q;
`endif
    case (state_q)
      IDLE:        if (tms) state_d = SEL1;
      SEL_SHIFT:   state_d = tms ? SHIFT : SEL2;
      SEL_CAPTURE: state_d = tms ? CAPTURE : SEL3;
      // The operand is taken at commit so it is already stable during RUN
      SEL_ENC: begin
        if (tms) begin
          state_d   = RUN;
          mode_d    = MODE_ENC;
          operand_d = chain[CELL_W-1:0];
        end else begin
          state_d = SEL4;
        end
      end
      SEL_DEC: begin
        if (tms) begin
          state_d   = RUN;
          mode_d    = MODE_DEC;
          operand_d = chain[LAST_LSB +: CELL_W];
        end else begin
          state_d = UPDATE;
        end
      end
      SHIFT: begin
`ifdef SCAN_BYPASS_EN
        if (byp_sel) begin
          tdo_d = byp_q;
          byp_d = tdi;
        end else begin
          tdo_d    = chain[0];
          shift_en = 1'b1;
        end
`else
        tdo_d    = chain[0];
        shift_en = 1'b1;
`endif
        state_d = tms ? SHIFT : IDLE;
      end
      CAPTURE: begin
        load_en = 1'b1;
        state_d = IDLE;
      end
      UPDATE: begin
        upd_data_d  = chain;
        upd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      RUN: begin
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Done has priority over the timeout on the same cycle
        if (eng_done) begin
          wr_en   = 1'b1;
          wr_idx  = (mode_q == MODE_DEC) ? IDX_W'(NUM_CELLS - 1) : '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge trst) begin
    if (trst) begin
      state_q     <= IDLE;
      tdo_q       <= 1'b0;
      upd_data_q  <= '0;
      upd_valid_q <= 1'b0;
      mode_q      <= MODE_ENC;
      operand_q   <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tdo_q       <= tdo_d;
      upd_data_q  <= upd_data_d;
      upd_valid_q <= upd_valid_d;
      mode_q      <= mode_d;
      operand_q   <= operand_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

`ifdef SCAN_BYPASS_EN
  always_ff @(posedge clk or posedge trst) begin
    if (trst) begin
      byp_q <= 1'b0;
    end else begin
      byp_q <= byp_d;
    end
  end
`endif

  assign tdo         = tdo_q;
  assign upd_data    = upd_data_q;
  assign upd_valid   = upd_valid_q;
  assign eng_start   = (state_q == RUN);
  assign eng_mode    = mode_q;
  assign eng_operand = operand_q;
  assign busy        = (state_q == RUN) || (state_q == WAIT);
  assign err         = err_q;

endmodule
